// File: rtl/window_buffer2d.sv
// Sliding KxK window generator for a raster pixel stream.
// K-1 line memories form a vertical tap column that feeds a shifting window register.
module window_buffer2d #(
   parameter int DataBitWidth = 12,
   parameter int WindowSize   = 5,
   parameter int LineWidth    = 640,
   parameter int FrameHeight  = 480
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              en,
   input  logic                                              d_valid,
   input  logic                                              sof,
   input  logic signed [DataBitWidth-1:0]                    d_in,
   output logic [WindowSize*WindowSize*DataBitWidth-1:0]     win_out,
   output logic                                              win_valid,
   output logic                                              frame_done
);

   localparam int K  = WindowSize;
   localparam int DW = DataBitWidth;
   localparam int CW = $clog2(LineWidth);
   localparam int RW = $clog2(FrameHeight);
   localparam int WW = K * K * DW;

   localparam logic [CW-1:0] COL_LAST = CW'(LineWidth - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FrameHeight - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

   logic              w_accept;
   logic [CW-1:0]     w_col;
   logic [RW-1:0]     w_row;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [(K-1)*DW-1:0] w_taps;
   logic [K*DW-1:0]   w_col_new;
   logic [WW-1:0]     r_win;
   logic              r_win_valid;
   logic              r_frame_done;

   assign w_accept = en & d_valid;
   // A start-of-frame pixel is treated as sitting at row 0, col 0 whatever the counters say.
   assign w_col    = sof ? {CW{1'b0}} : r_col;
   assign w_row    = sof ? {RW{1'b0}} : r_row;

   for (genvar j = 0; j < K - 1; j++) begin : g_line
      logic [DW-1:0] r_mem [LineWidth];
      logic [DW-1:0] w_wr;

      if (j == 0) begin : g_head
         assign w_wr = d_in;
      end else begin : g_chain
         assign w_wr = w_taps[(j-1)*DW +: DW];
      end

      // Line memory write; contents deliberately survive reset and sof.
      always_ff @(posedge clk) begin
         if (w_accept) begin
            r_mem[w_col] <= w_wr;
         end
      end

      assign w_taps[j*DW +: DW] = r_mem[w_col];
   end

   // Row K-1 of the new column is the live pixel; row 0 comes from the oldest line.
   assign w_col_new[(K-1)*DW +: DW] = d_in;
   for (genvar r = 0; r < K - 1; r++) begin : g_tap
      assign w_col_new[r*DW +: DW] = w_taps[(K-2-r)*DW +: DW];
   end

   // Raster position counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= {CW{1'b0}};
         r_row <= {RW{1'b0}};
      end else if (w_accept) begin
         if (w_col == COL_LAST) begin
            r_col <= {CW{1'b0}};
            r_row <= (w_row == ROW_LAST) ? {RW{1'b0}} : w_row + RW'(1);
         end else begin
            r_col <= w_col + CW'(1);
            r_row <= w_row;
         end
      end
   end

   // Window register: shift columns toward index 0, load the new column at K-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win <= {WW{1'b0}};
      end else if (w_accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               r_win[(r*K+c)*DW +: DW] <= r_win[(r*K+c+1)*DW +: DW];
            end
            r_win[(r*K+K-1)*DW +: DW] <= w_col_new[r*DW +: DW];
         end
      end
   end

   // Status flags from pre-increment position; sof forces position 0 so frame_done stays low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_valid  <= w_accept & (w_row >= ROW_WIN) & (w_col >= COL_WIN);
         r_frame_done <= w_accept & (w_col == COL_LAST) & (w_row == ROW_LAST);
      end
   end

   assign win_out    = r_win;
   assign win_valid  = r_win_valid;
   assign frame_done = r_frame_done;

endmodule

// File: doc/window_buffer2d.md
WINDOW_BUFFER2D -- requirements
Module: window_buffer2d

Interface
REQ-001 SHALL have parameter DataBitWidth, default 12, meaning signed pixel width in bits.
REQ-002 SHALL have parameter WindowSize, default 5, meaning window edge K; legal values are odd and at least 3.
REQ-003 SHALL have parameter LineWidth, default 640, meaning pixels per row; legal values are at least WindowSize.
REQ-004 SHALL have parameter FrameHeight, default 480, meaning rows per frame; legal values are at least WindowSize.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit, global enable; 0 freezes all state.
REQ-008 SHALL have port d_valid, input, 1 bit, d_in qualifier.
REQ-009 SHALL have port sof, input, 1 bit, start of frame; sampled only with an accepted pixel.
REQ-010 SHALL have port d_in, input, signed DataBitWidth bits, raster-order pixel.
REQ-011 SHALL have port win_out, output, K*K*DataBitWidth bits, packed window.
REQ-012 SHALL have port win_valid, output, 1 bit, win_out holds a complete window.
REQ-013 SHALL have port frame_done, output, 1 bit, one-cycle pulse after the last pixel of a frame.

Function
REQ-014 SHALL define accept = en & d_valid; only accepted pixels advance state.
REQ-015 SHALL keep col_cnt (0..LineWidth-1) and row_cnt (0..FrameHeight-1), each $clog2 width; on accept col_cnt increments; at LineWidth-1 it wraps to 0 and row_cnt increments; row_cnt wraps to 0 after FrameHeight-1.
REQ-016 SHALL treat an accepted pixel with sof=1 as row 0, col 0: counters after that edge are col 1, row 0, regardless of prior position.
REQ-017 SHALL hold K-1 line memories of LineWidth entries; on accept, line j is written with line j-1's output at col_cnt, and line 0 is written with d_in, forming a vertical K-tap column.
REQ-018 SHALL hold a KxK window register; on accept, all columns shift one place toward index 0 and the new rightmost column is {d_in, line outputs} at col_cnt.
REQ-019 SHALL pack element (r,c) at bit offset (r*K+c)*DataBitWidth; r=0 is the oldest row, c=0 is the oldest column; element (K-1,K-1) is the newest pixel.
REQ-020 SHALL register win_valid <= accept & (row_cnt >= K-1) & (col_cnt >= K-1), evaluated on the pre-increment counters; latency is 1 cycle from accept.
REQ-021 SHALL deassert win_valid on any cycle without accept; win_out holds its value while not accepting.
REQ-022 SHALL keep win_valid low for cols 0..K-2 of every row: no wrap-around windows spanning two rows.
REQ-023 SHALL register frame_done <= accept & (col_cnt == LineWidth-1) & (row_cnt == FrameHeight-1).
REQ-024 SHALL give sof priority over the frame_done condition when both apply to the same pixel: frame_done stays low.
REQ-025 SHALL not clear line memory contents on sof; stale data is never flagged because of REQ-020.
REQ-026 SHALL make win_out arithmetic-free: a pure copy of the pixel values with no sign extension.

Reset
REQ-027 SHALL, while rst=1 (asynchronously), force col_cnt, row_cnt, the window registers and win_out to 0, and win_valid and frame_done to 0.
REQ-028 SHALL not reset line memories; the first frame after reset is correct without clearing them.
REQ-029 SHALL treat a reset mid-frame as equivalent to a later sof on the first accepted pixel.

Verification (K=3, LineWidth=8, FrameHeight=6, DataBitWidth=12, pixel = row*16+col)
REQ-030 SHALL cover ramp with sof on the first pixel and d_valid constantly high: first win_valid one cycle after the 19th pixel (0x022), with elements (0,0)=0x000, (1,1)=0x011 and (2,2)=0x022.
REQ-031 SHALL cover row wrap: win_valid low after pixels 0x030 and 0x031, high after 0x032, whose window has (0,0)=0x010.
REQ-032 SHALL cover a stall where d_valid=0 or en=0 for 3 cycles mid-row: win_valid is 0 and win_out is unchanged; the next accept resumes with the correct window.
REQ-033 SHALL cover frame end: frame_done pulses exactly once, one cycle after pixel 0x057; the next pixel with sof restarts, and the first window again follows 0x022.
REQ-034 SHALL cover rst asserted mid-row 3 without a clock edge: outputs go to 0 immediately; after release, sof-less pixels are treated as row 0, col 0.
REQ-035 SHALL cover sof asserted at row 4, col 5: counters restart, and win_valid stays low until the 19th pixel after it.
